// File: rtl/icache_fetch.sv
// ----------------------------------------------------------------------------
// icache_fetch
// Direct-mapped instruction cache that answers the fetch stage. A lookup hit
// returns the instruction in the same cycle. On a miss the cache reads one
// word from the memory arbiter, fills the frame, and then compares again.
// iHit is also the advance strobe of the IF/ID latch.
//
// Ports
//   CLK       in   clock, rising edge
//   nRST      in   asynchronous, active-low reset
//   imemREN   in   datapath instruction request
//   imemaddr  in   byte address: [IDX_W+1:2] index, upper bits tag, [1:0] ignored
//   iHit      out  imemload holds the word for imemaddr this cycle
//   imemload  out  instruction word, 0 when iHit=0
//   iREN      out  memory-side read request
//   iaddr     out  memory-side word address (latched miss address)
//   iwait     in   memory busy; iload is valid when iREN=1 and iwait=0
//   iload     in   memory read data
//   hit_cnt   out  saturating count of hit cycles
//   miss_cnt  out  saturating count of misses started
// ----------------------------------------------------------------------------
module icache_fetch #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              iHit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  typedef enum logic {COMPARE, FETCH} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [WORD_W-1:0]  r_data [SETS];
  logic [WORD_W-1:0]  r_missAddr;
  logic [CNT_W-1:0]   r_hitCnt;
  logic [CNT_W-1:0]   r_missCnt;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_fillIdx;
  logic [TAG_W-1:0]   w_fillTag;
  logic               w_lookupHit;
  logic               w_missStart;
  logic               w_fillDone;
  logic               w_unusedOffset;

  assign w_idx          = imemaddr[IDX_W+1:2];
  assign w_tag          = imemaddr[WORD_W-1:IDX_W+2];
  assign w_fillIdx      = r_missAddr[IDX_W+1:2];
  assign w_fillTag      = r_missAddr[WORD_W-1:IDX_W+2];
  assign w_unusedOffset = ^{imemaddr[1:0], r_missAddr[1:0]};

  assign w_lookupHit = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_fillDone  = (r_state == FETCH) & ~iwait;

  assign hit_cnt  = r_hitCnt;
  assign miss_cnt = r_missCnt;

  // Next state and outputs. While FETCH is active the memory address comes
  // from the latched miss address, never from the live imemaddr, and iHit
  // stays low even when the live address would hit another frame.
  always_comb begin
    w_nextState = r_state;
    iHit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    w_missStart = 1'b0;
    case (r_state)
      COMPARE: begin
        if (w_lookupHit) begin
          iHit     = 1'b1;
          imemload = r_data[w_idx];
        end else if (imemREN) begin
          w_missStart = 1'b1;
          w_nextState = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = r_missAddr;
        if (!iwait) w_nextState = COMPARE;
      end
      default: w_nextState = COMPARE;
    endcase
  end

  // State, valid bits, miss address and counters. Reset clears every valid
  // bit, so a fill that was in flight is simply forgotten.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      r_state    <= COMPARE;
      r_valid    <= '0;
      r_missAddr <= '0;
      r_hitCnt   <= '0;
      r_missCnt  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_fillDone) r_valid[w_fillIdx] <= 1'b1;
      if (w_missStart) begin
        r_missAddr <= {imemaddr[WORD_W-1:2], 2'b00};
        if (r_missCnt != '1) r_missCnt <= r_missCnt + CNT_W'(1);
      end
      if (iHit && (r_hitCnt != '1)) r_hitCnt <= r_hitCnt + CNT_W'(1);
    end
  end

  // Tag and data arrays need no reset; they are qualified by r_valid.
  always_ff @(posedge CLK) begin
    if (w_fillDone) begin
      r_tag[w_fillIdx]  <= w_fillTag;
      r_data[w_fillIdx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// ----------------------------------------------------------------------------
// tb_icache_fetch
// Self-checking bench for icache_fetch: a directed vector table covering the
// miss/fill/hit sequences, a hand-written reset-during-fetch sequence, and a
// randomized run checked against a line-level cache model. Counters are
// built 4 bits wide so that saturation is reached within the random run.
// ----------------------------------------------------------------------------
module tb_icache_fetch;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          imemREN = 1'b0;
  logic [31:0]   imemaddr = '0;
  logic          iHit;
  logic [31:0]   imemload;
  logic          iREN;
  logic [31:0]   iaddr;
  logic          iwait = 1'b1;
  logic [31:0]   iload = '0;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  int total = 0;
  int bad = 0;

  icache_fetch #(.SETS(16), .WORD_W(32), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .iHit(iHit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        wt;
    logic [31:0] ld;
    logic        eHit;
    logic [31:0] eLoad;
    logic        eREN;
    logic [31:0] eAddr;
    int          eHc;
    int          eMc;
  } vec_t;

  vec_t vecs[$];

  // Line-level model: each index remembers which word address it holds.
  bit          mLineValid [16];
  logic [31:0] mLineWord  [16];
  logic [31:0] mLineData  [16];
  bit          mFetching;
  logic [31:0] mMissAddr;
  int          mHits;
  int          mMisses;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and let outputs settle.
  task automatic applyStimulus(input logic ren, input logic [31:0] addr,
                               input logic wt, input logic [31:0] ld);
    @(negedge CLK);
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = ld;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic eHit, input logic [31:0] eLoad,
                             input logic eREN, input logic [31:0] eAddr,
                             input int eHc, input int eMc);
    checkVal({tag, ".iHit"},     {31'b0, iHit},     {31'b0, eHit});
    checkVal({tag, ".imemload"}, imemload,          eLoad);
    checkVal({tag, ".iREN"},     {31'b0, iREN},     {31'b0, eREN});
    checkVal({tag, ".iaddr"},    iaddr,             eAddr);
    checkVal({tag, ".hit_cnt"},  32'(hit_cnt),      32'(eHc));
    checkVal({tag, ".miss_cnt"}, 32'(miss_cnt),     32'(eMc));
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mLineValid[i] = 1'b0;
      mLineWord[i]  = '0;
      mLineData[i]  = '0;
    end
    mFetching = 1'b0;
    mMissAddr = '0;
    mHits     = 0;
    mMisses   = 0;
  endtask

  task automatic doReset();
    @(negedge CLK);
    nRST = 1'b0;
    imemREN = 1'b0;
    iwait = 1'b1;
    #1;
    checkOutput("reset", 1'b0, '0, 1'b0, '0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;
    modelReset();
  endtask

  task automatic addVec(input logic ren, input logic [31:0] addr, input logic wt,
                        input logic [31:0] ld, input logic eHit, input logic [31:0] eLoad,
                        input logic eREN, input logic [31:0] eAddr, input int eHc, input int eMc);
    vec_t v;
    v.ren = ren; v.addr = addr; v.wt = wt; v.ld = ld;
    v.eHit = eHit; v.eLoad = eLoad; v.eREN = eREN; v.eAddr = eAddr;
    v.eHc = eHc; v.eMc = eMc;
    vecs.push_back(v);
  endtask

  // Expected values are the state before the rising edge of each row.
  task automatic buildTable();
    addVec(1, 32'h40,  1, 0,            0, 0,            0, 0,      0, 0);
    addVec(1, 32'h40,  1, 0,            0, 0,            1, 32'h40, 0, 1);
    addVec(1, 32'h40,  1, 0,            0, 0,            1, 32'h40, 0, 1);
    addVec(1, 32'h40,  1, 0,            0, 0,            1, 32'h40, 0, 1);
    addVec(1, 32'h40,  0, 32'h20010005, 0, 0,            1, 32'h40, 0, 1);
    addVec(1, 32'h40,  1, 0,            1, 32'h20010005, 0, 0,      0, 1);
    addVec(1, 32'h40,  1, 0,            1, 32'h20010005, 0, 0,      1, 1);
    addVec(1, 32'h40,  1, 0,            1, 32'h20010005, 0, 0,      2, 1);
    addVec(1, 32'h40,  1, 0,            1, 32'h20010005, 0, 0,      3, 1);
    addVec(1, 32'h440, 1, 0,            0, 0,            0, 0,      4, 1);
    addVec(1, 32'h440, 0, 32'hDEADBEEF, 0, 0,            1, 32'h440,4, 2);
    addVec(1, 32'h440, 1, 0,            1, 32'hDEADBEEF, 0, 0,      4, 2);
    addVec(1, 32'h40,  1, 0,            0, 0,            0, 0,      5, 2);
    addVec(0, 32'h40,  0, 32'h20010005, 0, 0,            1, 32'h40, 5, 3);
    addVec(0, 32'h40,  1, 0,            0, 0,            0, 0,      5, 3);
    addVec(1, 32'h80,  1, 0,            0, 0,            0, 0,      5, 3);
    addVec(1, 32'h100, 1, 0,            0, 0,            1, 32'h80, 5, 4);
    addVec(1, 32'h100, 0, 32'h11112222, 0, 0,            1, 32'h80, 5, 4);
    addVec(1, 32'h100, 1, 0,            0, 0,            0, 0,      5, 4);
    addVec(1, 32'h100, 0, 32'h33334444, 0, 0,            1, 32'h100,5, 5);
    addVec(1, 32'h100, 1, 0,            1, 32'h33334444, 0, 0,      5, 5);
    addVec(1, 32'h44,  1, 0,            0, 0,            0, 0,      6, 5);
    addVec(1, 32'h44,  0, 32'h55556666, 0, 0,            1, 32'h44, 6, 6);
    addVec(1, 32'h44,  1, 0,            1, 32'h55556666, 0, 0,      6, 6);
    addVec(1, 32'h40,  1, 0,            0, 0,            0, 0,      7, 6);
    addVec(1, 32'h44,  1, 0,            0, 0,            1, 32'h40, 7, 7);
    addVec(1, 32'h44,  0, 32'h77778888, 0, 0,            1, 32'h40, 7, 7);
    addVec(1, 32'h44,  1, 0,            1, 32'h55556666, 0, 0,      7, 7);
    addVec(1, 32'h40,  1, 0,            1, 32'h77778888, 0, 0,      8, 7);
  endtask

  // One randomized cycle: predict from the model, compare, then advance it.
  task automatic randomCycle(input int n);
    logic        ren, wt, eHit, eREN;
    logic [31:0] addr, ld, word, eLoad, eAddr;
    int          idx;
    ren  = ($urandom_range(0, 9) < 8);
    wt   = $urandom_range(0, 1);
    ld   = $urandom;
    addr = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) addr = addr | (32'($urandom_range(1, 15)) << 28);
    word = {addr[31:2], 2'b00};
    idx  = int'(addr[5:2]);
    applyStimulus(ren, addr, wt, ld);
    if (!mFetching) begin
      eHit  = ren && mLineValid[idx] && (mLineWord[idx] == word);
      eLoad = eHit ? mLineData[idx] : 32'h0;
      eREN  = 1'b0;
      eAddr = 32'h0;
    end else begin
      eHit  = 1'b0;
      eLoad = 32'h0;
      eREN  = 1'b1;
      eAddr = mMissAddr;
    end
    checkOutput($sformatf("rand%0d", n), eHit, eLoad, eREN, eAddr, mHits, mMisses);
    if (!mFetching) begin
      if (eHit) mHits = (mHits < CMAX) ? mHits + 1 : CMAX;
      else if (ren) begin
        mMissAddr = word;
        mMisses   = (mMisses < CMAX) ? mMisses + 1 : CMAX;
        mFetching = 1'b1;
      end
    end else if (!wt) begin
      idx = int'(mMissAddr[5:2]);
      mLineValid[idx] = 1'b1;
      mLineWord[idx]  = mMissAddr;
      mLineData[idx]  = ld;
      mFetching = 1'b0;
    end
  endtask

  initial begin
    modelReset();
    buildTable();
    doReset();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ren, vecs[i].addr, vecs[i].wt, vecs[i].ld);
      checkOutput($sformatf("vec%0d", i), vecs[i].eHit, vecs[i].eLoad, vecs[i].eREN,
                  vecs[i].eAddr, vecs[i].eHc, vecs[i].eMc);
    end

    // Reset in the middle of a fetch: request drops at once and the frame
    // filled earlier for 0x40 no longer hits.
    applyStimulus(1, 32'h80, 1, 0);
    applyStimulus(1, 32'h80, 1, 0);
    checkVal("midfetch.iREN",  {31'b0, iREN}, 32'h1);
    checkVal("midfetch.iaddr", iaddr, 32'h80);
    #1 nRST = 1'b0;
    #1;
    checkOutput("asyncReset", 1'b0, '0, 1'b0, '0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;
    imemREN = 1'b1;
    imemaddr = 32'h40;
    iwait = 1'b1;
    #1;
    checkOutput("postReset", 1'b0, '0, 1'b0, '0, 0, 0);
    applyStimulus(1, 32'h40, 1, 0);
    checkOutput("postResetFetch", 1'b0, '0, 1'b1, 32'h40, 0, 1);

    doReset();
    for (int n = 0; n < 3000; n++) randomCycle(n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
